// File: rtl/ncm_bridge_n.sv
// Debug-NoC <-> system-NoC converter: narrow->wide deserialiser, wide->narrow serialiser
// with per-packet vchannel lock, packet-locked output arbitration and a dropped-packet counter.
module ncm_bridge_n #(
    parameter int NOC_DATA_WIDTH    = 32,
    parameter int DBG_DATA_WIDTH    = 16,
    parameter int NOC_VCHANNELS     = 3,
    parameter int NOC_USED_VCHANNEL = 0,
    parameter int DBG_DEST_WIDTH    = 5,
    parameter int DBG_CLASS_WIDTH   = 3,
    parameter logic [DBG_CLASS_WIDTH-1:0] DBG_CLASS   = 3'h4,
    parameter logic [DBG_DEST_WIDTH-1:0]  EXT_IF_DEST = 5'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sys_halted,
    input  logic [DBG_DATA_WIDTH+1:0] dbg_in_flit,
    input  logic                      dbg_in_valid,
    output logic                      dbg_in_ready,
    input  logic                      conf_in_ready,
    output logic [DBG_DATA_WIDTH+1:0] dbg_out_flit,
    output logic                      dbg_out_valid,
    input  logic                      dbg_out_ready,
    input  logic [DBG_DATA_WIDTH+1:0] conf_out_flit,
    input  logic                      conf_out_valid,
    output logic                      conf_out_ready,
    input  logic [NOC_DATA_WIDTH+1:0] noc_in_flit,
    input  logic [NOC_VCHANNELS-1:0]  noc_in_valid,
    output logic [NOC_VCHANNELS-1:0]  noc_in_ready,
    output logic [NOC_DATA_WIDTH+1:0] noc_out_flit,
    output logic [NOC_VCHANNELS-1:0]  noc_out_valid,
    input  logic [NOC_VCHANNELS-1:0]  noc_out_ready,
    output logic [7:0]                drop_count
);
    localparam int RATIO  = NOC_DATA_WIDTH / DBG_DATA_WIDTH;
    localparam int SLOT_W = $clog2(RATIO);
    localparam int VC_W   = (NOC_VCHANNELS > 1) ? $clog2(NOC_VCHANNELS) : 1;
    localparam int ID_W   = DBG_DATA_WIDTH - DBG_DEST_WIDTH - DBG_CLASS_WIDTH;
    localparam logic [1:0] FT_PAYLOAD = 2'b00, FT_HEADER = 2'b01, FT_TAIL = 2'b10, FT_SINGLE = 2'b11;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RATIO - 1);

    typedef enum logic [1:0] {D_IDLE, D_COLLECT, D_EMIT} dstate_t;
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_SER} sstate_t;
    typedef enum logic [1:0] {O_NONE, O_CONF, O_DATA} owner_t;

    logic [NOC_VCHANNELS-1:0] in_valid_eff, out_ready_eff;
    assign in_valid_eff  = noc_in_valid  & ~{NOC_VCHANNELS{sys_halted}};
    assign out_ready_eff = noc_out_ready & ~{NOC_VCHANNELS{sys_halted}};

    // Narrow -> wide deserialiser
    dstate_t d_state, d_state_nxt;
    logic [NOC_DATA_WIDTH-1:0] d_word, d_word_nxt;
    logic [SLOT_W-1:0] d_slot, d_slot_nxt;
    logic d_first, d_first_nxt, d_last, d_last_nxt, d_drop;
    logic [1:0] in_type;
    logic [DBG_DATA_WIDTH-1:0] in_data;
    logic in_fire, wout_fire;

    assign in_type      = dbg_in_flit[DBG_DATA_WIDTH +: 2];
    assign in_data      = dbg_in_flit[DBG_DATA_WIDTH-1:0];
    assign dbg_in_ready = conf_in_ready & (d_state != D_EMIT);
    assign in_fire      = dbg_in_valid & dbg_in_ready;
    assign wout_fire    = (d_state == D_EMIT) & out_ready_eff[NOC_USED_VCHANNEL];

    always_comb begin
        d_state_nxt = d_state;
        d_word_nxt  = d_word;
        d_slot_nxt  = d_slot;
        d_first_nxt = d_first;
        d_last_nxt  = d_last;
        d_drop      = 1'b0;
        unique case (d_state)
            D_IDLE: if (in_fire) begin
                if (in_type == FT_HEADER) begin
                    d_state_nxt = D_COLLECT;
                    d_first_nxt = 1'b1;
                    d_slot_nxt  = '0;
                end else if (in_type == FT_SINGLE) begin
                    d_drop = 1'b1;
                end
            end
            D_COLLECT: if (in_fire) begin
                if (in_type == FT_HEADER) begin
                    d_drop      = 1'b1;
                    d_first_nxt = 1'b1;
                    d_slot_nxt  = '0;
                end else if (in_type == FT_SINGLE) begin
                    d_drop      = 1'b1;
                    d_state_nxt = D_IDLE;
                end else begin
                    // Slot 0 clears the word so a short TAIL leaves the low slots zero.
                    if (d_slot == '0) d_word_nxt = '0;
                    d_word_nxt[NOC_DATA_WIDTH-1-int'(d_slot)*DBG_DATA_WIDTH -: DBG_DATA_WIDTH] = in_data;
                    if (in_type == FT_TAIL || d_slot == LAST_SLOT) begin
                        d_state_nxt = D_EMIT;
                        d_last_nxt  = (in_type == FT_TAIL);
                    end else begin
                        d_slot_nxt = d_slot + SLOT_W'(1);
                    end
                end
            end
            D_EMIT: if (wout_fire) begin
                d_state_nxt = d_last ? D_IDLE : D_COLLECT;
                d_first_nxt = 1'b0;
                d_slot_nxt  = '0;
            end
            default: d_state_nxt = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_state    <= D_IDLE;
            d_slot     <= '0;
            d_first    <= 1'b0;
            d_last     <= 1'b0;
            drop_count <= '0;
        end else begin
            d_state <= d_state_nxt;
            d_slot  <= d_slot_nxt;
            d_first <= d_first_nxt;
            d_last  <= d_last_nxt;
            if (d_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk) d_word <= d_word_nxt;

    logic [1:0] wtype;
    always_comb begin
        if (d_first && d_last) wtype = FT_SINGLE;
        else if (d_first)      wtype = FT_HEADER;
        else if (d_last)       wtype = FT_TAIL;
        else                   wtype = FT_PAYLOAD;
        noc_out_valid = '0;
        noc_out_valid[NOC_USED_VCHANNEL] = (d_state == D_EMIT);
        noc_out_flit = (d_state == D_EMIT) ? {wtype, d_word} : '0;
    end

    // Wide -> narrow serialiser with per-packet vchannel lock
    sstate_t s_state, s_state_nxt;
    logic [NOC_DATA_WIDTH-1:0] s_word, s_word_nxt;
    logic [SLOT_W-1:0] s_slot, s_slot_nxt;
    logic s_last, s_last_nxt, lock_valid, lock_valid_nxt;
    logic [VC_W-1:0] lock_vc, lock_vc_nxt, sel_vc;
    logic sel_hit, w_fire, ser_valid, ser_ready, ser_fire;
    logic [1:0] w_type;
    logic [DBG_DATA_WIDTH+1:0] ser_flit;

    assign w_type = noc_in_flit[NOC_DATA_WIDTH +: 2];

    always_comb begin
        sel_vc  = '0;
        sel_hit = 1'b0;
        for (int i = NOC_VCHANNELS - 1; i >= 0; i--) begin
            if (in_valid_eff[i]) begin
                sel_vc  = VC_W'(i);
                sel_hit = 1'b1;
            end
        end
        if (lock_valid) begin
            sel_vc  = lock_vc;
            sel_hit = in_valid_eff[lock_vc];
        end
        noc_in_ready = '0;
        if (s_state == S_IDLE && (lock_valid || sel_hit)) noc_in_ready[sel_vc] = 1'b1;
    end

    assign w_fire    = (s_state == S_IDLE) & sel_hit;
    assign ser_valid = (s_state == S_HDR) | (s_state == S_SER);
    assign ser_fire  = ser_valid & ser_ready;

    always_comb begin
        if (s_state == S_HDR)
            ser_flit = {FT_HEADER, EXT_IF_DEST, DBG_CLASS, {ID_W{1'b0}}};
        else
            ser_flit = {(s_slot == LAST_SLOT && s_last) ? FT_TAIL : FT_PAYLOAD,
                        s_word[NOC_DATA_WIDTH-1-int'(s_slot)*DBG_DATA_WIDTH -: DBG_DATA_WIDTH]};
    end

    always_comb begin
        s_state_nxt    = s_state;
        s_word_nxt     = s_word;
        s_slot_nxt     = s_slot;
        s_last_nxt     = s_last;
        lock_valid_nxt = lock_valid;
        lock_vc_nxt    = lock_vc;
        unique case (s_state)
            S_IDLE: if (w_fire) begin
                lock_valid_nxt = 1'b1;
                lock_vc_nxt    = sel_vc;
                s_word_nxt     = noc_in_flit[NOC_DATA_WIDTH-1:0];
                s_last_nxt     = (w_type == FT_TAIL) || (w_type == FT_SINGLE);
                s_slot_nxt     = '0;
                s_state_nxt    = (w_type == FT_HEADER || w_type == FT_SINGLE) ? S_HDR : S_SER;
            end
            S_HDR: if (ser_fire) begin
                s_state_nxt = S_SER;
                s_slot_nxt  = '0;
            end
            S_SER: if (ser_fire) begin
                if (s_slot == LAST_SLOT) begin
                    s_state_nxt = S_IDLE;
                    if (s_last) lock_valid_nxt = 1'b0;
                end else begin
                    s_slot_nxt = s_slot + SLOT_W'(1);
                end
            end
            default: s_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_state    <= S_IDLE;
            s_slot     <= '0;
            s_last     <= 1'b0;
            lock_valid <= 1'b0;
            lock_vc    <= '0;
        end else begin
            s_state    <= s_state_nxt;
            s_slot     <= s_slot_nxt;
            s_last     <= s_last_nxt;
            lock_valid <= lock_valid_nxt;
            lock_vc    <= lock_vc_nxt;
        end
    end

    always_ff @(posedge clk) s_word <= s_word_nxt;

    // Output arbitration: a grant taken at NONE is held until the packet's end flit leaves
    owner_t owner, owner_nxt, cur;
    logic [1:0] out_type;
    logic out_fire;

    always_comb begin
        cur = owner;
        if (owner == O_NONE) begin
            if (conf_out_valid) cur = O_CONF;
            else if (ser_valid) cur = O_DATA;
        end
        dbg_out_valid = 1'b0;
        dbg_out_flit  = '0;
        unique case (cur)
            O_CONF: begin
                dbg_out_valid = conf_out_valid;
                dbg_out_flit  = conf_out_valid ? conf_out_flit : '0;
            end
            O_DATA: begin
                dbg_out_valid = ser_valid;
                dbg_out_flit  = ser_valid ? ser_flit : '0;
            end
            default: ;
        endcase
        out_type  = dbg_out_flit[DBG_DATA_WIDTH +: 2];
        out_fire  = dbg_out_valid & dbg_out_ready;
        owner_nxt = (out_fire && (out_type == FT_TAIL || out_type == FT_SINGLE)) ? O_NONE : cur;
    end

    assign ser_ready      = dbg_out_ready & (cur == O_DATA);
    assign conf_out_ready = dbg_out_ready & (cur == O_CONF);

    always_ff @(posedge clk) begin
        if (rst) owner <= O_NONE;
        else     owner <= owner_nxt;
    end
endmodule

// File: tb/tb_ncm_bridge_n.sv
// Scoreboard bench for ncm_bridge_n: stimulus pushes expected flits, monitors pop on each output transfer.
module tb_ncm_bridge_n;
    localparam logic [1:0] H = 2'b01, P = 2'b00, T = 2'b10, S = 2'b11;
    localparam logic [17:0] NHDR = {2'b01, 16'h0400};

    logic clk = 1'b0, rst = 1'b1, sys_halted = 1'b0;
    logic [17:0] dbg_in_flit = '0, dbg_out_flit, conf_out_flit = '0;
    logic dbg_in_valid = 1'b0, dbg_in_ready, conf_in_ready = 1'b1;
    logic dbg_out_valid, dbg_out_ready = 1'b1, conf_out_valid = 1'b0, conf_out_ready;
    logic [33:0] noc_in_flit = '0, noc_out_flit;
    logic [2:0] noc_in_valid = '0, noc_in_ready, noc_out_valid, noc_out_ready = 3'b111;
    logic [7:0] drop_count;

    int checks = 0, errors = 0;
    logic [36:0] exp_w[$];
    logic [17:0] exp_n[$];

    always #5 clk = ~clk;

    ncm_bridge_n dut (
        .clk(clk), .rst(rst), .sys_halted(sys_halted),
        .dbg_in_flit(dbg_in_flit), .dbg_in_valid(dbg_in_valid), .dbg_in_ready(dbg_in_ready),
        .conf_in_ready(conf_in_ready),
        .dbg_out_flit(dbg_out_flit), .dbg_out_valid(dbg_out_valid), .dbg_out_ready(dbg_out_ready),
        .conf_out_flit(conf_out_flit), .conf_out_valid(conf_out_valid), .conf_out_ready(conf_out_ready),
        .noc_in_flit(noc_in_flit), .noc_in_valid(noc_in_valid), .noc_in_ready(noc_in_ready),
        .noc_out_flit(noc_out_flit), .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready),
        .drop_count(drop_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake timed out", name);
    endtask

    // Output monitors
    always @(negedge clk) begin
        if (!rst) begin
            if ((noc_out_valid & noc_out_ready & ~{3{sys_halted}}) != 3'b000) begin
                if (exp_w.size() == 0) chk("wide_unexpected", {noc_out_valid, noc_out_flit}, '0);
                else chk("wide_out", {noc_out_valid, noc_out_flit}, exp_w.pop_front());
            end
            if (dbg_out_valid && dbg_out_ready) begin
                if (exp_n.size() == 0) chk("narrow_unexpected", dbg_out_flit, '0);
                else chk("narrow_out", dbg_out_flit, exp_n.pop_front());
            end
        end
    end

    task automatic send_narrow(input logic [1:0] ty, input logic [15:0] d);
        bit ok;
        int n;
        dbg_in_flit = {ty, d};
        dbg_in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = dbg_in_ready;
            @(posedge clk);
            n++;
        end while (!ok && n < 1000);
        #1 dbg_in_valid = 1'b0;
        if (!ok) timeout("send_narrow");
    endtask

    task automatic send_conf(input logic [1:0] ty, input logic [15:0] d);
        bit ok;
        int n;
        conf_out_flit = {ty, d};
        conf_out_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = conf_out_ready;
            @(posedge clk);
            n++;
        end while (!ok && n < 1000);
        #1 conf_out_valid = 1'b0;
        if (!ok) timeout("send_conf");
    endtask

    task automatic send_wide(input int vc, input logic [1:0] ty, input logic [31:0] d);
        bit ok;
        int n;
        noc_in_flit = {ty, d};
        noc_in_valid = '0;
        noc_in_valid[vc] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = noc_in_ready[vc] && !sys_halted;
            @(posedge clk);
            n++;
        end while (!ok && n < 1000);
        #1 noc_in_valid = '0;
        if (!ok) timeout("send_wide");
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_w.size() != 0 || exp_n.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_wide_left", exp_w.size(), 0);
        chk("drain_narrow_left", exp_n.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_dbg_in_ready", dbg_in_ready, 1);
        chk("rst_noc_out_valid", noc_out_valid, 0);
        chk("rst_dbg_out_valid", dbg_out_valid, 0);
        chk("rst_noc_in_ready", noc_in_ready, 0);
        chk("rst_conf_out_ready", conf_out_ready, 0);
        chk("rst_drop_count", drop_count, 0);
        @(posedge clk); #1;

        // Narrow packet folded into two wide words
        exp_w.push_back({3'b001, H, 32'hAAAABBBB});
        exp_w.push_back({3'b001, T, 32'hCCCC0000});
        send_narrow(H, 16'h0000);
        send_narrow(P, 16'hAAAA);
        send_narrow(P, 16'hBBBB);
        send_narrow(T, 16'hCCCC);
        drain();
        chk("t1_drop_count", drop_count, 0);

        // vchannel lock: vc2 waits for vc1's tail
        exp_n.push_back(NHDR); exp_n.push_back({P, 16'hAAAA}); exp_n.push_back({P, 16'h5555});
        exp_n.push_back({P, 16'h0000}); exp_n.push_back({T, 16'hBEEF});
        exp_n.push_back(NHDR); exp_n.push_back({P, 16'h1234}); exp_n.push_back({T, 16'h5678});
        send_wide(1, H, 32'hAAAA5555);
        noc_in_flit = {S, 32'h12345678};
        noc_in_valid = 3'b100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_vc2_stalled", noc_in_ready[2], 0);
        end
        @(posedge clk); #1 noc_in_valid = '0;
        send_wide(1, T, 32'h0000BEEF);
        send_wide(2, S, 32'h12345678);
        drain();

        // Config packet waits for the data packet in flight
        exp_n.push_back(NHDR); exp_n.push_back({P, 16'h1111}); exp_n.push_back({P, 16'h2222});
        exp_n.push_back({P, 16'h3333}); exp_n.push_back({T, 16'h4444});
        exp_n.push_back({H, 16'h0ABC}); exp_n.push_back({T, 16'h0DEF});
        fork
            begin
                send_wide(0, H, 32'h11112222);
                send_wide(0, T, 32'h33334444);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                send_conf(H, 16'h0ABC);
                send_conf(T, 16'h0DEF);
            end
        join
        drain();

        // Halt: wide side frozen, narrow side drains
        exp_n.push_back(NHDR); exp_n.push_back({P, 16'h9999}); exp_n.push_back({T, 16'hAAAA});
        exp_w.push_back({3'b001, S, 32'h51510000});
        exp_n.push_back(NHDR); exp_n.push_back({P, 16'h0F0F}); exp_n.push_back({T, 16'h1E1E});
        send_wide(0, S, 32'h9999AAAA);
        sys_halted = 1'b1;
        fork
            send_wide(1, S, 32'h0F0F1E1E);
            begin
                send_narrow(H, 16'h0000);
                send_narrow(T, 16'h5151);
                repeat (20) @(posedge clk);
                @(negedge clk);
                chk("halt_word_held", noc_out_valid, 3'b001);
                chk("halt_in_ready", noc_in_ready[1], 0);
                chk("halt_narrow_drained", exp_n.size(), 3);
                chk("halt_wide_pending", exp_w.size(), 1);
                @(posedge clk); #1 sys_halted = 1'b0;
            end
        join
        drain();

        // Drop counting and saturation
        for (int i = 0; i < 3; i++) send_narrow(S, 16'h00FF);
        exp_w.push_back({3'b001, S, 32'h77770000});
        send_narrow(H, 16'h0000);
        send_narrow(H, 16'h0000);
        send_narrow(T, 16'h7777);
        drain();
        chk("drop_count_4", drop_count, 4);
        for (int i = 0; i < 300; i++) send_narrow(S, 16'h0001);
        chk("drop_count_sat", drop_count, 8'hFF);

        // Reset in the middle of serialisation
        exp_n.push_back(NHDR); exp_n.push_back({P, 16'h0102}); exp_n.push_back({P, 16'h0304});
        send_wide(0, H, 32'h01020304);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_n.delete();
        @(negedge clk);
        chk("mid_rst_dbg_out_valid", dbg_out_valid, 0);
        chk("mid_rst_noc_out_valid", noc_out_valid, 0);
        chk("mid_rst_noc_in_ready", noc_in_ready, 0);
        chk("mid_rst_drop_count", drop_count, 0);
        @(posedge clk); #1;
        exp_n.push_back(NHDR); exp_n.push_back({P, 16'hCAFE}); exp_n.push_back({T, 16'hF00D});
        send_wide(0, S, 32'hCAFEF00D);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
